// File: rtl/ma_pkg.sv
// ma_pkg
// Shared definitions for the SimpleRISC memory-access stage controller:
// the FSM state encoding, pipeline field widths, and the MA/RW entry layout
// carried by the one-entry output register.
package ma_pkg;

  // Pipeline field widths
  localparam int RegIdxW = 4;
  localparam int DataW   = 32;

  // IDLE accepts new work; LD_WAIT parks the stage until DM answers a load
  typedef enum logic {
    IDLE    = 1'b0,
    LD_WAIT = 1'b1
  } state_t;

  // One MA/RW entry as presented to the RW stage
  typedef struct packed {
    logic [DataW-1:0]   ldresult;
    logic [DataW-1:0]   alu;
    logic [RegIdxW-1:0] rd;
    logic               wb;
    logic               isLd;
  } ma_entry_t;

endpackage

// File: rtl/ma_stage_ctrl_if.sv
// ma_stage_ctrl_if
// Bundles the three buses around the MA stage: the EX/MA input handshake,
// the data-memory port and the MA/RW output handshake, plus the sticky
// error flag.
//   slave  : the MA stage controller itself
//   master : the surroundings (EX stage, data memory, RW stage)
// Parameter N is the DM word-address width and must match the controller.
interface ma_stage_ctrl_if #(
  parameter int N = 7
);
  import ma_pkg::*;

  // EX/MA input side
  logic                in_valid;
  logic                in_ready;
  logic                in_is_ld;
  logic                in_is_st;
  logic [DataW-1:0]    in_addr;
  logic [DataW-1:0]    in_stdata;
  logic [DataW-1:0]    in_alu;
  logic [RegIdxW-1:0]  in_rd;
  logic                in_wb;

  // Data-memory port
  logic                dm_ena;
  logic                dm_wea;
  logic [N-1:0]        dm_addra;
  logic [DataW-1:0]    dm_dina;
  logic [DataW-1:0]    dm_douta;
  logic                dm_done;

  // MA/RW output side
  logic                out_valid;
  logic                out_ready;
  logic [DataW-1:0]    out_ldresult;
  logic [DataW-1:0]    out_alu;
  logic [RegIdxW-1:0]  out_rd;
  logic                out_wb;
  logic                out_is_ld;

  logic                err;

  modport slave (
    input  in_valid, in_is_ld, in_is_st, in_addr, in_stdata, in_alu, in_rd, in_wb,
    output in_ready,
    output dm_ena, dm_wea, dm_addra, dm_dina,
    input  dm_douta, dm_done,
    output out_valid, out_ldresult, out_alu, out_rd, out_wb, out_is_ld,
    input  out_ready,
    output err
  );

  modport master (
    output in_valid, in_is_ld, in_is_st, in_addr, in_stdata, in_alu, in_rd, in_wb,
    input  in_ready,
    input  dm_ena, dm_wea, dm_addra, dm_dina,
    output dm_douta, dm_done,
    input  out_valid, out_ldresult, out_alu, out_rd, out_wb, out_is_ld,
    output out_ready,
    input  err
  );

endinterface

// File: rtl/ma_out_reg.sv
// ma_out_reg
// One-entry valid/ready holding register between MA and RW.
// Ports:
//   clka, rst_n : clock and asynchronous active-low reset
//   load_i      : a new entry is written this cycle
//   entry_i     : the entry to write
//   ready_i     : RW consumes the current entry
//   valid_o     : an entry is being presented
//   entry_o     : the presented entry
module ma_out_reg
  import ma_pkg::*;
(
  input  logic      clka,
  input  logic      rst_n,
  input  logic      load_i,
  input  ma_entry_t entry_i,
  input  logic      ready_i,
  output logic      valid_o,
  output ma_entry_t entry_o
);

  logic      valid_q, valid_d;
  ma_entry_t entry_q, entry_d;

  // A load always wins, so a same-cycle consume plus reload keeps valid high
  // with the new data; otherwise a consume simply empties the slot.
  always_comb begin
    valid_d = valid_q;
    entry_d = entry_q;
    if (load_i) begin
      valid_d = 1'b1;
      entry_d = entry_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      entry_q <= '0;
    end else begin
      valid_q <= valid_d;
      entry_q <= entry_d;
    end
  end

  assign valid_o = valid_q;
  assign entry_o = entry_q;

endmodule

// File: rtl/ma_stage_ctrl.sv
// ma_stage_ctrl
// Memory-access stage controller of the SimpleRISC pipeline. Takes one
// instruction per EX/MA handshake, issues at most one DM access for it,
// waits for dm_done on loads and hands the result to RW through a one-entry
// output register. Malformed instructions, out-of-range addresses and load
// timeouts raise the sticky err flag.
// Ports:
//   clka  : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of ma_stage_ctrl_if (EX/MA in, DM port, MA/RW out, err)
// Parameters:
//   N       : DM word-address width
//   TIMEOUT : cycles to wait for dm_done after a load issue
module ma_stage_ctrl
  import ma_pkg::*;
#(
  parameter int N       = 7,
  parameter int TIMEOUT = 4
) (
  input  logic           clka,
  input  logic           rst_n,
  ma_stage_ctrl_if.slave bus
);

  localparam int                TimerW    = $clog2(TIMEOUT + 1);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [TimerW-1:0]  timer_q, timer_d;
  logic               err_q, err_d;
  logic [DataW-1:0]   holdAlu_q;
  logic [RegIdxW-1:0] holdRd_q;
  logic               holdWb_q;

  logic      inReady, accept, isLoad, isStore, issue, addrHigh;
  logic      ldDone, ldTimeout, outValid, loadNew;
  ma_entry_t newEntry, outEntry;

  // Both opcode bits set is treated as a load, so the store decode excludes it
  assign isLoad    = bus.in_is_ld;
  assign isStore   = bus.in_is_st & ~bus.in_is_ld;
  assign inReady   = (state_q == IDLE) & (~outValid | bus.out_ready);
  assign accept    = bus.in_valid & inReady;
  assign issue     = accept & (isLoad | isStore);
  assign addrHigh  = |bus.in_addr[DataW-1:N+2];
  assign ldDone    = (state_q == LD_WAIT) & bus.dm_done;
  // The timer reaches TIMEOUT on the edge that closes this cycle
  assign ldTimeout = (state_q == LD_WAIT) & ~bus.dm_done & (timer_q == TimerLast);

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept && isLoad)       state_d = LD_WAIT;
      LD_WAIT: if (ldDone || ldTimeout)    state_d = IDLE;
      default:                             state_d = IDLE;
    endcase
  end

  // Output decode: DM strobes are purely combinational from the accept, and
  // the output register is fed either directly from EX (non-loads) or from
  // the holding registers once the load resolves.
  always_comb begin
    timer_d  = timer_q;
    err_d    = err_q;
    loadNew  = 1'b0;
    newEntry = '0;

    if (accept && isLoad) begin
      timer_d = '0;
    end else if (state_q == LD_WAIT) begin
      timer_d = timer_q + TimerW'(1);
    end

    if ((accept && bus.in_is_ld && bus.in_is_st) || (issue && addrHigh) || ldTimeout) begin
      err_d = 1'b1;
    end

    if (accept && !isLoad) begin
      loadNew       = 1'b1;
      newEntry.alu  = bus.in_alu;
      newEntry.rd   = bus.in_rd;
      newEntry.wb   = bus.in_wb;
    end else if (ldDone || ldTimeout) begin
      loadNew           = 1'b1;
      newEntry.ldresult = ldDone ? bus.dm_douta : '0;
      newEntry.alu      = holdAlu_q;
      newEntry.rd       = holdRd_q;
      newEntry.wb       = holdWb_q;
      newEntry.isLd     = 1'b1;
    end
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      timer_q   <= '0;
      err_q     <= 1'b0;
      holdAlu_q <= '0;
      holdRd_q  <= '0;
      holdWb_q  <= 1'b0;
    end else begin
      timer_q <= timer_d;
      err_q   <= err_d;
      if (accept && isLoad) begin
        holdAlu_q <= bus.in_alu;
        holdRd_q  <= bus.in_rd;
        holdWb_q  <= bus.in_wb;
      end
    end
  end

  ma_out_reg u_out_reg (
    .clka    (clka),
    .rst_n   (rst_n),
    .load_i  (loadNew),
    .entry_i (newEntry),
    .ready_i (bus.out_ready),
    .valid_o (outValid),
    .entry_o (outEntry)
  );

  assign bus.in_ready     = inReady;
  assign bus.dm_ena       = issue;
  assign bus.dm_wea       = accept & isStore;
  assign bus.dm_addra     = issue ? bus.in_addr[N+1:2] : '0;
  assign bus.dm_dina      = (accept && isStore) ? bus.in_stdata : '0;
  assign bus.out_valid    = outValid;
  assign bus.out_ldresult = outEntry.ldresult;
  assign bus.out_alu      = outEntry.alu;
  assign bus.out_rd       = outEntry.rd;
  assign bus.out_wb       = outEntry.wb;
  assign bus.out_is_ld    = outEntry.isLd;
  assign bus.err          = err_q;

endmodule

// File: tb/tb_ma_stage_ctrl.sv
// tb_ma_stage_ctrl
// Self-checking bench for ma_stage_ctrl. A behavioural data memory answers
// loads one cycle after issue; a reference memory and an expected-entry
// queue predict what RW should see.
module tb_ma_stage_ctrl;
  import ma_pkg::*;

  localparam int N       = 7;
  localparam int TIMEOUT = 4;

  logic clka  = 1'b0;
  logic rst_n = 1'b0;
  always #5 clka = ~clka;

  ma_stage_ctrl_if #(.N(N)) bus ();

  ma_stage_ctrl #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clka  (clka),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int passes = 0;

  // Data memory seen by the DUT and the bench's own reference copy
  logic [31:0] dmMem    [0:127];
  logic [31:0] modelMem [0:127];
  logic        dmDoneQ   = 1'b0;
  logic [31:0] dmDoutQ   = '0;
  bit          dmRespond = 1'b1;
  logic        strayDone = 1'b0;

  assign bus.dm_done  = dmDoneQ | strayDone;
  assign bus.dm_douta = dmDoutQ;

  // Memory responder: writes on store strobes, answers loads one cycle later
  always @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      dmDoneQ <= 1'b0;
      dmDoutQ <= '0;
    end else begin
      dmDoneQ <= 1'b0;
      if (bus.dm_ena && !bus.dm_wea && dmRespond) begin
        dmDoneQ <= 1'b1;
        dmDoutQ <= dmMem[bus.dm_addra];
      end
      if (bus.dm_ena && bus.dm_wea) dmMem[bus.dm_addra] = bus.dm_dina;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog");
  end

  task automatic applyStimulus(input logic v, input logic ld, input logic st,
                               input logic [31:0] addr, input logic [31:0] sdata,
                               input logic [31:0] alu, input logic [3:0] rd, input logic wb);
    bus.in_valid  = v;
    bus.in_is_ld  = ld;
    bus.in_is_st  = st;
    bus.in_addr   = addr;
    bus.in_stdata = sdata;
    bus.in_alu    = alu;
    bus.in_rd     = rd;
    bus.in_wb     = wb;
  endtask

  task automatic doReset();
    @(negedge clka);
    rst_n = 1'b0;
    @(negedge clka);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clka);
    #1;
    checks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL rst_out_valid: got %b want 0", bus.out_valid); else passes++;
    checks++; if ({bus.out_ldresult, bus.out_alu, bus.out_rd, bus.out_wb, bus.out_is_ld} !== '0)
      $display("[TB] FAIL rst_out_fields: got ld=%h alu=%h rd=%h wb=%b isld=%b want all 0", bus.out_ldresult, bus.out_alu, bus.out_rd, bus.out_wb, bus.out_is_ld);
    else passes++;
    checks++; if (bus.err !== 1'b0) $display("[TB] FAIL rst_err: got %b want 0", bus.err); else passes++;
    checks++; if (bus.dm_ena !== 1'b0) $display("[TB] FAIL rst_dm_ena: got %b want 0", bus.dm_ena); else passes++;
    rst_n = 1'b1;
    @(negedge clka);
    #1;
    checks++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL rst_in_ready: got %b want 1", bus.in_ready); else passes++;
  endtask

  task automatic test_store_load();
    bus.out_ready = 1'b1;
    @(negedge clka);
    applyStimulus(1, 0, 1, 32'h10, 32'hDEADBEEF, 32'h10, 4'd1, 1'b0);
    #1;
    checks++; if (bus.dm_ena !== 1'b1 || bus.dm_wea !== 1'b1) $display("[TB] FAIL st_strobe: got ena=%b wea=%b want 1 1", bus.dm_ena, bus.dm_wea); else passes++;
    checks++; if (bus.dm_addra !== 7'd4) $display("[TB] FAIL st_addr: got %0d want 4", bus.dm_addra); else passes++;
    checks++; if (bus.dm_dina !== 32'hDEADBEEF) $display("[TB] FAIL st_data: got %h want deadbeef", bus.dm_dina); else passes++;
    modelMem[4] = 32'hDEADBEEF;
    @(negedge clka);
    applyStimulus(1, 1, 0, 32'h10, 32'h0, 32'h10, 4'd5, 1'b1);
    #1;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_ldresult !== 32'h0 || bus.out_is_ld !== 1'b0)
      $display("[TB] FAIL st_out: got v=%b ld=%h isld=%b want 1 0 0", bus.out_valid, bus.out_ldresult, bus.out_is_ld);
    else passes++;
    checks++; if (bus.dm_ena !== 1'b1 || bus.dm_wea !== 1'b0 || bus.in_ready !== 1'b1)
      $display("[TB] FAIL ld_issue: got ena=%b wea=%b rdy=%b want 1 0 1", bus.dm_ena, bus.dm_wea, bus.in_ready);
    else passes++;
    @(negedge clka);
    applyStimulus(0, 0, 0, 32'h0, 32'h0, 32'h0, 4'd0, 1'b0);
    #1;
    checks++; if (bus.dm_ena !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0)
      $display("[TB] FAIL ld_wait: got ena=%b rdy=%b v=%b want 0 0 0", bus.dm_ena, bus.in_ready, bus.out_valid);
    else passes++;
    @(negedge clka);
    #1;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_ldresult !== modelMem[4] || bus.out_is_ld !== 1'b1 || bus.out_rd !== 4'd5)
      $display("[TB] FAIL ld_result: got v=%b ld=%h isld=%b rd=%0d want 1 %h 1 5", bus.out_valid, bus.out_ldresult, bus.out_is_ld, bus.out_rd, modelMem[4]);
    else passes++;
    checks++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL ld_ready_back: got %b want 1", bus.in_ready); else passes++;
    @(negedge clka);
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clka);
      if (i <= 3) applyStimulus(1, 0, 0, 32'h0, 32'h0, 32'(i), 4'(i), 1'b1);
      else        applyStimulus(0, 0, 0, 32'h0, 32'h0, 32'h0, 4'd0, 1'b0);
      #1;
      if (i <= 3) begin
        checks++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL b2b_ready%0d: got %b want 1", i, bus.in_ready); else passes++;
      end
      if (i >= 2) begin
        checks++; if (bus.out_valid !== 1'b1 || bus.out_alu !== 32'(i - 1))
          $display("[TB] FAIL b2b_out%0d: got v=%b alu=%0d want 1 %0d", i, bus.out_valid, bus.out_alu, i - 1);
        else passes++;
      end
    end
  endtask

  task automatic test_backpressure();
    @(negedge clka);
    bus.out_ready = 1'b0;
    applyStimulus(1, 0, 0, 32'h0, 32'h0, 32'hA1, 4'd3, 1'b1);
    @(negedge clka);
    applyStimulus(1, 0, 0, 32'h0, 32'h0, 32'hB2, 4'd4, 1'b0);
    #1;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_alu !== 32'hA1) $display("[TB] FAIL bp_first: got v=%b alu=%h want 1 a1", bus.out_valid, bus.out_alu); else passes++;
    checks++; if (bus.in_ready !== 1'b0) $display("[TB] FAIL bp_stall: got %b want 0", bus.in_ready); else passes++;
    @(negedge clka);
    #1;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_alu !== 32'hA1 || bus.out_rd !== 4'd3)
      $display("[TB] FAIL bp_hold: got v=%b alu=%h rd=%0d want 1 a1 3", bus.out_valid, bus.out_alu, bus.out_rd);
    else passes++;
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL bp_release: got %b want 1", bus.in_ready); else passes++;
    @(negedge clka);
    applyStimulus(0, 0, 0, 32'h0, 32'h0, 32'h0, 4'd0, 1'b0);
    #1;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_alu !== 32'hB2 || bus.out_rd !== 4'd4)
      $display("[TB] FAIL bp_new: got v=%b alu=%h rd=%0d want 1 b2 4", bus.out_valid, bus.out_alu, bus.out_rd);
    else passes++;
    @(negedge clka);
    #1;
    checks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL bp_drain: got %b want 0", bus.out_valid); else passes++;
  endtask

  task automatic test_random();
    ma_entry_t   q[$];
    ma_entry_t   exp;
    logic        pending = 1'b0;
    logic        prevLoadIssue = 1'b0;
    logic        ld = 1'b0, st = 1'b0, wb = 1'b0;
    logic [31:0] a = '0, sd = '0, alu = '0;
    logic [3:0]  rd = '0;
    int          kind;
    for (int cyc = 0; cyc < 410; cyc++) begin
      @(negedge clka);
      if (cyc < 400) begin
        if (!pending && $urandom_range(0, 3) != 0) begin
          kind = $urandom_range(0, 2);
          ld = (kind == 2);
          st = (kind == 1);
          a = $urandom & 32'h1FF;
          sd = $urandom;
          alu = $urandom;
          rd = 4'($urandom);
          wb = 1'($urandom);
          pending = 1'b1;
        end
        applyStimulus(pending, ld, st, a, sd, alu, rd, wb);
        bus.out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 32'h0, 4'd0, 1'b0);
        bus.out_ready = 1'b1;
      end
      #1;
      if (prevLoadIssue) begin
        checks++; if (bus.dm_ena !== 1'b0) $display("[TB] FAIL rand_ena_gap: got %b want 0 at cycle %0d", bus.dm_ena, cyc); else passes++;
      end
      prevLoadIssue = bus.dm_ena & ~bus.dm_wea;
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (q.size() == 0) begin
          $display("[TB] FAIL rand_unexpected: got out_valid with alu=%h want no entry", bus.out_alu);
        end else begin
          exp = q.pop_front();
          if (bus.out_ldresult !== exp.ldresult || bus.out_alu !== exp.alu || bus.out_rd !== exp.rd ||
              bus.out_wb !== exp.wb || bus.out_is_ld !== exp.isLd)
            $display("[TB] FAIL rand_out: got ld=%h alu=%h rd=%0d wb=%b isld=%b want ld=%h alu=%h rd=%0d wb=%b isld=%b",
                     bus.out_ldresult, bus.out_alu, bus.out_rd, bus.out_wb, bus.out_is_ld,
                     exp.ldresult, exp.alu, exp.rd, exp.wb, exp.isLd);
          else passes++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp.ldresult = ld ? modelMem[a[8:2]] : 32'h0;
        exp.alu      = alu;
        exp.rd       = rd;
        exp.wb       = wb;
        exp.isLd     = ld;
        if (st) modelMem[a[8:2]] = sd;
        q.push_back(exp);
        pending = 1'b0;
      end
    end
    checks++; if (q.size() != 0) $display("[TB] FAIL rand_leftover: got %0d pending entries want 0", q.size()); else passes++;
  endtask

  task automatic test_timeout();
    int lat = 0;
    dmRespond = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clka);
    applyStimulus(1, 1, 0, 32'h20, 32'h0, 32'h77, 4'd9, 1'b1);
    #1;
    checks++; if (bus.err !== 1'b0 || bus.in_ready !== 1'b1) $display("[TB] FAIL to_pre: got err=%b rdy=%b want 0 1", bus.err, bus.in_ready); else passes++;
    for (int n = 1; n <= 12 && lat == 0; n++) begin
      @(negedge clka);
      applyStimulus(0, 0, 0, 32'h0, 32'h0, 32'h0, 4'd0, 1'b0);
      #1;
      if (bus.out_valid) begin
        lat = n;
        checks++; if (bus.err !== 1'b1 || bus.out_ldresult !== 32'h0 || bus.out_is_ld !== 1'b1 || bus.out_alu !== 32'h77)
          $display("[TB] FAIL to_entry: got err=%b ld=%h isld=%b alu=%h want 1 0 1 77", bus.err, bus.out_ldresult, bus.out_is_ld, bus.out_alu);
        else passes++;
      end else begin
        checks++; if (bus.in_ready !== 1'b0) $display("[TB] FAIL to_stall%0d: got %b want 0", n, bus.in_ready); else passes++;
      end
    end
    checks++; if (lat < TIMEOUT + 1 || lat > TIMEOUT + 2) $display("[TB] FAIL to_latency: got %0d want %0d..%0d", lat, TIMEOUT + 1, TIMEOUT + 2); else passes++;
    repeat (3) @(negedge clka);
    #1;
    checks++; if (bus.err !== 1'b1 || bus.out_valid !== 1'b0) $display("[TB] FAIL to_sticky: got err=%b v=%b want 1 0", bus.err, bus.out_valid); else passes++;
    dmRespond = 1'b1;
  endtask

  task automatic test_addr_error();
    doReset();
    #1;
    checks++; if (bus.err !== 1'b0) $display("[TB] FAIL ae_clear: got %b want 0", bus.err); else passes++;
    @(negedge clka);
    bus.out_ready = 1'b1;
    applyStimulus(1, 1, 0, 32'h0000_0400, 32'h0, 32'h400, 4'd2, 1'b1);
    #1;
    checks++; if (bus.dm_ena !== 1'b1 || bus.dm_addra !== 7'd0) $display("[TB] FAIL ae_addr: got ena=%b addr=%0d want 1 0", bus.dm_ena, bus.dm_addra); else passes++;
    @(negedge clka);
    applyStimulus(0, 0, 0, 32'h0, 32'h0, 32'h0, 4'd0, 1'b0);
    #1;
    checks++; if (bus.err !== 1'b1) $display("[TB] FAIL ae_err: got %b want 1", bus.err); else passes++;
    @(negedge clka);
    #1;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_ldresult !== modelMem[0])
      $display("[TB] FAIL ae_result: got v=%b ld=%h want 1 %h", bus.out_valid, bus.out_ldresult, modelMem[0]);
    else passes++;
  endtask

  task automatic test_both_ld_st();
    doReset();
    @(negedge clka);
    bus.out_ready = 1'b1;
    applyStimulus(1, 1, 1, 32'h8, 32'h1234_5678, 32'h8, 4'd7, 1'b1);
    #1;
    checks++; if (bus.dm_ena !== 1'b1 || bus.dm_wea !== 1'b0) $display("[TB] FAIL both_strobe: got ena=%b wea=%b want 1 0", bus.dm_ena, bus.dm_wea); else passes++;
    @(negedge clka);
    applyStimulus(0, 0, 0, 32'h0, 32'h0, 32'h0, 4'd0, 1'b0);
    #1;
    checks++; if (bus.err !== 1'b1) $display("[TB] FAIL both_err: got %b want 1", bus.err); else passes++;
    @(negedge clka);
    #1;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_is_ld !== 1'b1 || bus.out_ldresult !== modelMem[2])
      $display("[TB] FAIL both_result: got v=%b isld=%b ld=%h want 1 1 %h", bus.out_valid, bus.out_is_ld, bus.out_ldresult, modelMem[2]);
    else passes++;
  endtask

  task automatic test_reset_mid_load();
    logic sawValid = 1'b0;
    doReset();
    dmRespond = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clka);
    applyStimulus(1, 1, 0, 32'h30, 32'h0, 32'h5A, 4'd6, 1'b1);
    @(negedge clka);
    applyStimulus(0, 0, 0, 32'h0, 32'h0, 32'h0, 4'd0, 1'b0);
    @(negedge clka);
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.dm_ena !== 1'b0 || bus.err !== 1'b0 ||
                  {bus.out_ldresult, bus.out_alu, bus.out_rd, bus.out_wb, bus.out_is_ld} !== '0)
      $display("[TB] FAIL rml_reset: got v=%b ena=%b err=%b alu=%h rd=%0d want all 0", bus.out_valid, bus.dm_ena, bus.err, bus.out_alu, bus.out_rd);
    else passes++;
    @(negedge clka);
    rst_n = 1'b1;
    dmRespond = 1'b1;
    @(negedge clka);
    strayDone = 1'b1;
    @(negedge clka);
    strayDone = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (bus.out_valid) sawValid = 1'b1;
      @(negedge clka);
    end
    #1;
    checks++; if (sawValid !== 1'b0) $display("[TB] FAIL rml_stray: got out_valid=1 want 0"); else passes++;
    checks++; if (bus.in_ready !== 1'b1 || bus.err !== 1'b0) $display("[TB] FAIL rml_idle: got rdy=%b err=%b want 1 0", bus.in_ready, bus.err); else passes++;
  endtask

  initial begin
    logic [31:0] v;
    for (int i = 0; i < 128; i++) begin
      v = $urandom;
      dmMem[i] = v;
      modelMem[i] = v;
    end
    applyStimulus(0, 0, 0, 32'h0, 32'h0, 32'h0, 4'd0, 1'b0);
    bus.out_ready = 1'b0;
    $display("[TB] starting ma_stage_ctrl bench");
    test_reset();
    test_store_load();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_timeout();
    test_addr_error();
    test_both_ld_st();
    test_reset_mid_load();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
